// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with scoreboard for the pipelined core.
//
// Two combinational read ports (A/B) and two writeback ports (E from execute,
// M from memory). When both write ports name the same register, M wins. With
// BYPASS=1 the read ports see data being written back in the same cycle.
// A single busy bit per register tracks outstanding reservations from decode,
// and hazard flags a valid source that is busy and not satisfied by bypass.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   srcA/srcB -> valA/valB   read indices and data
//   wb_en, dstE/valE, dstM/valM   writeback strobe, indices and data
//   rsv_en, rsv_dstE, rsv_dstM    reservation strobe and indices from decode
//   hazard               a valid busy source is not covered by bypass
//   busy_vec             scoreboard bits, bit i = register i busy
//
// Any index equal to RNONE or >= NREGS is invalid. Invalid indices read as 0,
// never write, never reserve and never raise hazard.
module regfile_sb #(
  parameter int                DATA_W = 64,
  parameter int                NREGS  = 15,
  parameter int                ADDR_W = 4,
  parameter logic [ADDR_W-1:0] RNONE  = 4'hF,
  parameter int                BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_dstE,
  input  logic [ADDR_W-1:0] rsv_dstM,
  output logic              hazard,
  output logic [NREGS-1:0]  busy_vec
);

  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic              src_a_valid, src_b_valid;
  logic [DATA_W-1:0] stored_a, stored_b;
  logic              busy_a, busy_b;
  logic              hit_a, hit_b;

  function automatic logic idx_valid(input logic [ADDR_W-1:0] idx);
    return (idx != RNONE) && ({1'b0, idx} < NREGS_W);
  endfunction

  // Next-state for the array and scoreboard. M is applied after E so it
  // overrides on a shared index; a reservation is applied after the
  // writeback clear so the newer reservation stays outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_en && dstE == ADDR_W'(i)) regs_d[i] = valE;
      if (wb_en && dstM == ADDR_W'(i)) regs_d[i] = valM;
      if (wb_en && (dstE == ADDR_W'(i) || dstM == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (rsv_en && (rsv_dstE == ADDR_W'(i) || rsv_dstM == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  // Stored-array lookup done by comparison so an out-of-range index can
  // never address past the array; it simply matches nothing and yields 0.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    busy_a   = 1'b0;
    busy_b   = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA == ADDR_W'(i)) begin
        stored_a = regs_q[i];
        busy_a   = busy_q[i];
      end
      if (srcB == ADDR_W'(i)) begin
        stored_b = regs_q[i];
        busy_b   = busy_q[i];
      end
    end
  end

  assign src_a_valid = idx_valid(srcA);
  assign src_b_valid = idx_valid(srcB);

  // A source is satisfied in-cycle when either write port targets it.
  assign hit_a = (BYPASS != 0) && wb_en && src_a_valid && (dstE == srcA || dstM == srcA);
  assign hit_b = (BYPASS != 0) && wb_en && src_b_valid && (dstE == srcB || dstM == srcB);

  // Read priority: invalid -> 0, then M bypass, then E bypass, then array.
  always_comb begin
    valA = '0;
    if (src_a_valid) begin
      if ((BYPASS != 0) && wb_en && dstM == srcA)      valA = valM;
      else if ((BYPASS != 0) && wb_en && dstE == srcA) valA = valE;
      else                                             valA = stored_a;
    end
    valB = '0;
    if (src_b_valid) begin
      if ((BYPASS != 0) && wb_en && dstM == srcB)      valB = valM;
      else if ((BYPASS != 0) && wb_en && dstE == srcB) valB = valE;
      else                                             valB = stored_b;
    end
  end

  assign hazard   = (src_a_valid && busy_a && !hit_a) || (src_b_valid && busy_b && !hit_b);
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb. Two instances share every input: u_byp has
// BYPASS=1 and u_nob has BYPASS=0, so each step checks both read behaviours.
module tb_regfile_sb;

  localparam int DW = 64;
  localparam int NR = 15;
  localparam int AW = 4;
  localparam logic [AW-1:0] NONE = 4'hF;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] srcA, srcB, dstE, dstM, rsv_dstE, rsv_dstM;
  logic [DW-1:0] valE, valM;
  logic          wb_en, rsv_en;

  logic [DW-1:0] valA_1, valB_1, valA_0, valB_0;
  logic          hazard_1, hazard_0;
  logic [NR-1:0] busy_1, busy_0;

  int tests;
  int failed;

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .RNONE(NONE), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA_1), .valB(valB_1),
    .wb_en(wb_en), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rsv_en(rsv_en), .rsv_dstE(rsv_dstE), .rsv_dstM(rsv_dstM),
    .hazard(hazard_1), .busy_vec(busy_1)
  );

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .RNONE(NONE), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA_0), .valB(valB_0),
    .wb_en(wb_en), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rsv_en(rsv_en), .rsv_dstE(rsv_dstE), .rsv_dstM(rsv_dstM),
    .hazard(hazard_0), .busy_vec(busy_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic wb, input logic [AW-1:0] de, input logic [DW-1:0] ve,
                               input logic [AW-1:0] dm, input logic [DW-1:0] vm,
                               input logic rsv, input logic [AW-1:0] re, input logic [AW-1:0] rm,
                               input logic [AW-1:0] sa, input logic [AW-1:0] sb);
    wb_en = wb; dstE = de; valE = ve; dstM = dm; valM = vm;
    rsv_en = rsv; rsv_dstE = re; rsv_dstM = rm;
    srcA = sa; srcB = sb;
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] sa, input logic [AW-1:0] sb);
    applyStimulus(1'b0, NONE, '0, NONE, '0, 1'b0, NONE, NONE, sa, sb);
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    idle(4'd3, NONE);
    #10;

    // Reset state
    checkOutput("rst_valA", valA_1, 64'h0);
    checkOutput("rst_busy", {49'b0, busy_1}, 64'h0);
    checkOutput("rst_hazard", {63'b0, hazard_1}, 64'h0);
    rst_n = 1'b1;

    // Write reg3 then async reset mid-cycle
    tick();
    applyStimulus(1'b1, 4'd3, 64'hDEAD, NONE, '0, 1'b1, 4'd3, NONE, 4'd3, NONE);
    tick();
    idle(4'd3, NONE);
    checkOutput("wr3_valA", valA_1, 64'hDEAD);
    checkOutput("rsv3_busy", {49'b0, busy_1}, 64'h0008);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valA", valA_1, 64'h0);
    checkOutput("async_rst_busy", {49'b0, busy_1}, 64'h0);
    checkOutput("async_rst_hazard", {63'b0, hazard_1}, 64'h0);

    // Write presented as reset releases is applied on the next edge
    applyStimulus(1'b1, 4'd7, 64'hAB, NONE, '0, 1'b0, NONE, NONE, 4'd7, NONE);
    rst_n = 1'b1;
    tick();
    idle(4'd7, 4'd3);
    checkOutput("post_rst_wr7", valA_1, 64'hAB);
    checkOutput("post_rst_reg3", valB_1, 64'h0);

    // Dual write to the same register: M wins
    applyStimulus(1'b1, 4'd2, 64'h11, 4'd2, 64'h22, 1'b0, NONE, NONE, NONE, NONE);
    tick();
    idle(4'd2, NONE);
    checkOutput("dual_wr_byp", valA_1, 64'h22);
    checkOutput("dual_wr_nob", valA_0, 64'h22);

    // E port to RNONE, M port to reg14
    applyStimulus(1'b1, NONE, 64'h99, 4'hE, 64'h5, 1'b0, NONE, NONE, NONE, NONE);
    tick();
    idle(4'hE, 4'd2);
    checkOutput("wr14", valA_1, 64'h5);
    checkOutput("reg2_unchanged", valB_1, 64'h22);
    idle(4'd7, NONE);
    checkOutput("reg7_unchanged", valA_1, 64'hAB);

    // Bypass vs stored read
    applyStimulus(1'b1, 4'd5, 64'h7, NONE, '0, 1'b0, NONE, NONE, NONE, NONE);
    tick();
    applyStimulus(1'b1, 4'd5, 64'h9, NONE, '0, 1'b0, NONE, NONE, NONE, 4'd5);
    checkOutput("bypass_valB", valB_1, 64'h9);
    checkOutput("nobypass_valB", valB_0, 64'h7);
    tick();
    idle(NONE, 4'd5);
    checkOutput("nobypass_after_edge", valB_0, 64'h9);

    // M-over-E bypass priority, observed combinationally then withdrawn
    applyStimulus(1'b1, 4'd5, 64'h1, 4'd5, 64'h2, 1'b0, NONE, NONE, 4'd5, NONE);
    checkOutput("bypass_m_priority", valA_1, 64'h2);
    idle(NONE, NONE);

    // Scoreboard and hazard
    applyStimulus(1'b0, NONE, '0, NONE, '0, 1'b1, 4'd1, NONE, NONE, NONE);
    tick();
    idle(4'd1, NONE);
    checkOutput("rsv1_busy", {49'b0, busy_1}, 64'h0002);
    checkOutput("rsv1_hazard", {63'b0, hazard_1}, 64'h1);
    applyStimulus(1'b1, 4'd1, 64'h3, NONE, '0, 1'b0, NONE, NONE, 4'd1, NONE);
    checkOutput("wb1_hazard_byp", {63'b0, hazard_1}, 64'h0);
    checkOutput("wb1_valA_byp", valA_1, 64'h3);
    checkOutput("wb1_hazard_nob", {63'b0, hazard_0}, 64'h1);
    checkOutput("wb1_valA_nob", valA_0, 64'h0);
    tick();
    idle(4'd1, NONE);
    checkOutput("clr1_busy", {49'b0, busy_1}, 64'h0);
    checkOutput("clr1_hazard", {63'b0, hazard_0}, 64'h0);

    // Set and clear on the same register: set wins
    applyStimulus(1'b1, NONE, '0, 4'd6, 64'h66, 1'b1, NONE, 4'd6, NONE, NONE);
    tick();
    idle(NONE, NONE);
    checkOutput("setclr_busy", {49'b0, busy_1}, 64'h0040);
    checkOutput("rnone_valA", valA_1, 64'h0);
    checkOutput("rnone_valB", valB_1, 64'h0);
    checkOutput("rnone_hazard", {63'b0, hazard_1}, 64'h0);
    idle(NONE, 4'd6);
    checkOutput("busy6_hazard", {63'b0, hazard_1}, 64'h1);
    checkOutput("reg6_written", valB_1, 64'h66);

    // Reservation of RNONE is ignored
    applyStimulus(1'b0, NONE, '0, NONE, '0, 1'b1, NONE, NONE, NONE, NONE);
    tick();
    idle(NONE, NONE);
    checkOutput("rsv_rnone_busy", {49'b0, busy_0}, 64'h0040);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file for the pipelined processor core.
- Generalised data width and register count; two combinational read ports (A/B) and two write ports (E from execute, M from memory).
- Adds an asynchronous reset, a same-cycle write-to-read bypass, M-over-E write priority, and a per-register busy scoreboard with hazard detection.
- Sits between decode and writeback.

Parameters:
DATA_W, 64, register data width in bits
NREGS, 15, number of architectural registers; legal indices 0..NREGS-1
ADDR_W, 4, register index width; 2^ADDR_W must be greater than NREGS
RNONE, 4'hF, "no register" index; must be at least NREGS
BYPASS, 1, 1 = read ports see same-cycle writeback data; 0 = read ports see stored array only

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
srcA  input  ADDR_W  read port A index
srcB  input  ADDR_W  read port B index
valA  output  DATA_W  read port A data
valB  output  DATA_W  read port B data
wb_en  input  1  writeback strobe; qualifies dstE/dstM for this cycle
dstE  input  ADDR_W  write port E index
valE  input  DATA_W  write port E data
dstM  input  ADDR_W  write port M index
valM  input  DATA_W  write port M data
rsv_en  input  1  reserve strobe from decode; marks rsv_dstE/rsv_dstM busy
rsv_dstE  input  ADDR_W  register to reserve for an E write
rsv_dstM  input  ADDR_W  register to reserve for an M write
hazard  output  1  a valid source is busy and is not satisfied by bypass
busy_vec  output  NREGS  current scoreboard bits, bit i = register i busy

Behaviour:
- Index validity: an index is valid iff it is less than NREGS. RNONE and any out-of-range index are invalid everywhere: reads return 0, writes are dropped, reservations are ignored, and the index never raises hazard.
- Reset (rst_n low, asynchronous, any time including mid-write):
  - all NREGS registers := 0; busy_vec := 0.
  - valA/valB then read 0; hazard := 0.
  - Writes or reservations presented in the same cycle rst_n deasserts are not lost; the first rising edge with rst_n high applies normally.
- Reads are combinational, zero latency, evaluated per port X in {A,B} in this priority order:
  1. srcX invalid -> 0.
  2. BYPASS=1 && wb_en && dstM==srcX -> valM.
  3. BYPASS=1 && wb_en && dstE==srcX -> valE.
  4. Otherwise -> stored register[srcX].
- Writes occur at the rising edge when wb_en=1:
  - register[dstE] := valE if dstE is valid.
  - register[dstM] := valM if dstM is valid.
  - If dstE==dstM (valid), valM is stored and valE is discarded.
  - With wb_en=0, no write and no busy-bit clear.
- Scoreboard (busy_vec), per register i at each rising edge:
  - set_i = rsv_en && (rsv_dstE==i || rsv_dstM==i).
  - clr_i = wb_en && (dstE==i || dstM==i).
  - next busy_i = set_i ? 1 : (clr_i ? 0 : busy_i). When set and clear hit the same register in one cycle, set wins (the newer reservation is outstanding).
  - Only one busy bit per register: the scoreboard does not count multiple outstanding reservations. The issuing logic must stall on hazard before re-reserving a busy register.
  - Reserving an already-busy register leaves it busy; no error is flagged.
- Hazard, combinational:
  - hitX = BYPASS=1 && wb_en && srcX valid && (dstE==srcX || dstM==srcX).
  - hazard = (srcA valid && busy[srcA] && !hitA) || (srcB valid && busy[srcB] && !hitB).
  - With BYPASS=0, any busy valid source raises hazard, including one being written back in the current cycle.
- Width rules: data is passed through unmodified with no extension or truncation; busy_vec bit order matches register index.

Test Plan:
- Reset then read: pulse rst_n low mid-cycle after writing 64'hDEAD to reg 3 -> valA=0 for srcA=3 immediately after the async reset, busy_vec=0, hazard=0.
- Write/read with dual-write priority: wb_en=1, dstE=2, valE=64'h11, dstM=2, valM=64'h22 -> next cycle srcA=2 reads 64'h22; and dstE=RNONE, dstM=4'hE with valM=5 -> reg 14=5, no other register changes.
- Bypass: BYPASS=1, reg 5 holds 7; same cycle wb_en=1, dstE=5, valE=9, srcB=5 -> valB=9 combinationally; same stimulus with BYPASS=0 -> valB=7, then 9 after the edge.
- Scoreboard and hazard: rsv_en with rsv_dstE=1 -> busy_vec[1]=1; srcA=1 -> hazard=1; then wb_en, dstE=1, valE=3 -> hazard=0 that cycle with BYPASS=1 (valA=3), and busy_vec[1]=0 after the edge.
- Simultaneous set/clear: rsv_en with rsv_dstM=6 and wb_en with dstM=6 in the same cycle -> busy_vec[6]=1 after the edge; srcA=RNONE and srcB=RNONE -> valA=valB=0, hazard=0 regardless of busy_vec.
